// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit controller between a requester and a word-addressed data memory
// Ports: req_* accept one access in IDLE; rsp_* return the extended load data or error flag;
//        mem_* drive one load/store strobe per legal access; mem_data_out is the registered read data.
module lsu_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              mem_ld,
  output logic              mem_str,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] LWAIT  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;
  logic [1:0]        state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              error_q, error_d;
  logic              bad;
  logic [31:0]       shifted;
  logic [31:0]       ld_val;
  logic [3:0]        st_we;
  logic [31:0]       st_data;
  logic [1:0]        off;
  logic              in_access;
  logic              unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  // Decoded from the live request so errors skip ACCESS entirely.
  assign bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_store && req_funct3[2])
            || (req_funct3[1:0] == 2'b01 && req_addr[0])
            || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign off       = addr_q[1:0];
  assign shifted   = mem_data_out >> {off, 3'b000};
  // funct3[2] marks the unsigned variants, so it suppresses the sign bit.
  assign ld_val    = funct3_q[1] ? mem_data_out
                   : funct3_q[0] ? {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]}
                   : {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
  assign st_we     = funct3_q[1] ? 4'b1111 : funct3_q[0] ? 4'b0011 << off : 4'b0001 << off;
  assign st_data   = funct3_q[1] ? wdata_q : funct3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  // rst gates the strobes combinationally so an aborted store never writes.
  assign in_access   = (state_q == ACCESS) && !rst;
  assign mem_ld      = in_access && !store_q;
  assign mem_str     = in_access && store_q;
  assign mem_we      = mem_str ? st_we : 4'b0000;
  assign mem_data_in = mem_str ? st_data : 32'd0;
  assign mem_adr     = in_access ? addr_q[ADDR_W+1:2] : '0;
  assign req_ready   = (state_q == IDLE) && !rst;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = error_q;
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      IDLE: if (req_valid) begin
        store_d  = req_store;
        funct3_d = req_funct3;
        addr_d   = req_addr[ADDR_W+1:0];
        wdata_d  = req_wdata;
        rdata_d  = 32'd0;
        error_d  = bad;
        state_d  = bad ? RESP : ACCESS;
      end
      ACCESS: state_d = store_q ? RESP : LWAIT;
      LWAIT: begin
        rdata_d = ld_val;
        state_d = RESP;
      end
      default: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a registered-read memory model
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_ld, mem_str;
  logic [3:0]  mem_we;
  logic [11:0] mem_adr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = 32'd0;
  logic [31:0] mem [4096];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [49:0] mq[$];
  logic [32:0] rq[$];
  int          dq[$];
  logic        last_v = 1'b0, last_r = 1'b1, last_e = 1'b0;
  logic [31:0] last_d = 32'd0;

  lsu_ctrl #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .mem_ld(mem_ld),
    .mem_str(mem_str), .mem_we(mem_we), .mem_adr(mem_adr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_str)
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_adr][8*b +: 8] <= mem_data_in[8*b +: 8];
    if (mem_ld) mem_data_out <= mem[mem_adr];
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    logic [49:0] me;
    logic [32:0] re;
    int due;
    if (mem_ld || mem_str) begin
      if (mq.size() == 0) chk("mem_unexpected_strobe", {mem_ld, mem_str}, 2'b00);
      else begin
        me = mq.pop_front();
        chk("mem_ld", mem_ld, me[49]);
        chk("mem_str", mem_str, me[48]);
        chk("mem_adr", mem_adr, me[47:36]);
        chk("mem_we", mem_we, me[35:32]);
        chk("mem_data_in", mem_data_in, me[31:0]);
      end
    end else chk("mem_quiet", {mem_we, mem_adr, mem_data_in}, 48'd0);
    if (rsp_valid) chk("req_ready_in_resp", req_ready, 1'b0);
    if (rsp_valid && !last_v) begin
      if (rq.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
      else begin
        re = rq.pop_front();
        due = dq.pop_front();
        chk("rsp_rdata", rsp_rdata, re[31:0]);
        chk("rsp_error", rsp_error, re[32]);
        chk("rsp_latency", cyc, due);
      end
    end else if (rsp_valid && last_v) begin
      chk("rsp_hold_rdata", rsp_rdata, last_d);
      chk("rsp_hold_error", rsp_error, last_e);
    end
    if (last_v && !last_r) chk("rsp_hold_valid", rsp_valid, 1'b1);
    last_v = rsp_valid;
    last_r = rsp_ready;
    last_d = rsp_rdata;
    last_e = rsp_error;
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [11:0] adr, input logic [3:0] we, input logic [31:0] md);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", req_ready, 1'b1);
      return;
    end
    req_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    rq.push_back({exp_err, exp_rd});
    dq.push_back(cyc + (exp_err ? 1 : st ? 2 : 3));
    if (!exp_err) mq.push_back({~st, st, adr, we, md});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (rq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", rq.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    rst = 1'b1;
    #3;
    chk("reset_req_ready", req_ready, 1'b0);
    chk("reset_outputs", {rsp_valid, rsp_error, rsp_rdata, mem_ld, mem_str}, 36'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset_release_ready", req_ready, 1'b1);
    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 12'h004, 4'b1111, 32'hDEADBEEF);
    issue(1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, 12'h004, 4'b1000, 32'hA5A5A5A5);
    issue(0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 0, 12'h004, 4'b0000, 32'h0);
    issue(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 0, 12'h004, 4'b0000, 32'h0);
    issue(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 0, 12'h004, 4'b0000, 32'h0);
    issue(1, 3'b001, 32'h22, 32'h00008001, 32'h0, 0, 12'h008, 4'b1100, 32'h80018001);
    issue(0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 0, 12'h008, 4'b0000, 32'h0);
    issue(0, 3'b101, 32'h22, 32'h0, 32'h00008001, 0, 12'h008, 4'b0000, 32'h0);
    issue(0, 3'b010, 32'h4010, 32'h0, 32'hA5ADBEEF, 0, 12'h004, 4'b0000, 32'h0);
    issue(0, 3'b010, 32'h06, 32'h0, 32'h0, 1, 12'h0, 4'b0, 32'h0);
    issue(1, 3'b001, 32'h05, 32'h1234, 32'h0, 1, 12'h0, 4'b0, 32'h0);
    issue(0, 3'b011, 32'h00, 32'h0, 32'h0, 1, 12'h0, 4'b0, 32'h0);
    issue(1, 3'b100, 32'h00, 32'hFF, 32'h0, 1, 12'h0, 4'b0, 32'h0);
    drain();
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 12'h004, 4'b0000, 32'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_seen", rsp_valid, 1'b1);
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("hold_release_idle", {rsp_valid, req_ready}, 2'b01);
    issue(1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0, 12'h010, 4'b1111, 32'hCAFEF00D);
    drain();
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_store = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h40;
    req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort_in_access", mem_str, 1'b1);
    #2 rst = 1'b1;
    #1 chk("abort_strobes", {mem_str, mem_ld, mem_we, mem_data_in}, 38'd0);
    chk("abort_outputs", {rsp_valid, req_ready, rsp_error, rsp_rdata}, 35'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_release_ready", req_ready, 1'b1);
    issue(0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0, 12'h010, 4'b0000, 32'h0);
    drain();
    chk("mem_queue_empty", mq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
